// File: rtl/tff_bank_ctr_if.sv
// Control/data bundle for tff_bank_ctr: the bench drives the master side,
// and the bank implements the slave side.
interface tff_bank_ctr_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             chg;

  modport master (
    output en, mode, t, load_val,
    input  q, qb, tc, chg
  );

  modport slave (
    input  en, mode, t, load_val,
    output q, qb, tc, chg
  );
endinterface

// File: rtl/tff_bank_ctr.sv
// WIDTH-bit T flip-flop bank with toggle, up/down count and load modes.
// Define TFF_BANK_SAT_EN to make the count modes saturate instead of wrapping.
module tff_bank_ctr #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  tff_bank_ctr_if.slave bus
);

  localparam logic [WIDTH-1:0] Ones = '1;
  localparam logic [WIDTH-1:0] Zero = '0;
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        2'b00: q_d = q_q ^ bus.t;
        2'b01: begin
`ifdef TFF_BANK_SAT_EN
          q_d  = (q_q == Ones) ? q_q : q_q + One;
          tc_d = (q_d == Ones);
`else
          q_d  = q_q + One;
          tc_d = (q_q == Ones);
`endif
        end
        2'b10: begin
`ifdef TFF_BANK_SAT_EN
          q_d  = (q_q == Zero) ? q_q : q_q - One;
          tc_d = (q_d == Zero);
`else
          q_d  = q_q - One;
          tc_d = (q_q == Zero);
`endif
        end
        2'b11: q_d = bus.load_val;
        default: q_d = q_q;
      endcase
    end
    // With en low q_d equals q_q, so chg drops naturally on hold.
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= RST_VAL;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.qb  = ~q_q;
  assign bus.tc  = tc_q;
  assign bus.chg = chg_q;

endmodule

// File: tb/tb_tff_bank_ctr.sv
// Directed and randomized checks of tff_bank_ctr against an integer model.
`timescale 1ns/1ps
module tb_tff_bank_ctr;

  localparam int unsigned WIDTH   = 8;
  localparam int          MaxV    = 255;
  localparam logic [7:0]  RstVal  = 8'h5A;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  int   mq;
  bit   mtc;
  bit   mchg;

  tff_bank_ctr_if #(.WIDTH(WIDTH)) bus ();

  tff_bank_ctr #(
    .WIDTH   (WIDTH),
    .RST_VAL (RstVal)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour expressed with plain integer arithmetic.
  task automatic model(input bit r, input bit e, input int md, input int tv, input int lv);
    int nq;
    bit ntc;
    if (!r) begin
      mq = int'(RstVal); mtc = 0; mchg = 0;
      return;
    end
    if (!e) begin
      mtc = 0; mchg = 0;
      return;
    end
    nq  = mq;
    ntc = 0;
    case (md)
      0: nq = mq ^ tv;
      1: begin
`ifdef TFF_BANK_SAT_EN
        nq  = (mq == MaxV) ? MaxV : mq + 1;
        ntc = (nq == MaxV);
`else
        nq  = (mq + 1) % (MaxV + 1);
        ntc = (mq == MaxV);
`endif
      end
      2: begin
`ifdef TFF_BANK_SAT_EN
        nq  = (mq == 0) ? 0 : mq - 1;
        ntc = (nq == 0);
`else
        nq  = (mq + MaxV) % (MaxV + 1);
        ntc = (mq == 0);
`endif
      end
      default: nq = lv;
    endcase
    mchg = (nq != mq);
    mq   = nq;
    mtc  = ntc;
  endtask

  task automatic step(input bit r, input bit e, input int md, input int tv, input int lv,
                      input string tag);
    rst          = r;
    bus.en       = e;
    bus.mode     = 2'(md);
    bus.t        = 8'(tv);
    bus.load_val = 8'(lv);
    @(posedge clk);
    model(r, e, md, tv, lv);
    #1;
    check({tag, ".q"},   32'(bus.q),   32'(mq));
    check({tag, ".qb"},  32'(bus.qb),  32'((~mq) & MaxV));
    check({tag, ".tc"},  32'(bus.tc),  32'(mtc));
    check({tag, ".chg"}, 32'(bus.chg), 32'(mchg));
  endtask

  initial begin
    mq = 0; mtc = 0; mchg = 0;
    rst = 1'b0; bus.en = 1'b1; bus.mode = 2'b01; bus.t = '0; bus.load_val = '0;
    @(negedge clk);

    // Reset with en=1, mode=up, then release.
    step(0, 1, 1, 0, 0, "rst0");
    step(0, 1, 1, 0, 0, "rst1");
    step(1, 1, 1, 0, 0, "rel");

    // Toggle mode.
    step(1, 1, 3, 0, 8'h0F, "ld0f");
    step(1, 1, 0, 8'hFF, 0, "tgff");
    step(1, 1, 0, 8'h00, 0, "tg00");
    step(1, 1, 0, 8'h81, 0, "tg81");

    // Up wrap.
    step(1, 1, 3, 0, 8'hFE, "ldfe");
    for (int i = 0; i < 3; i++) step(1, 1, 1, $urandom, $urandom, "up");

    // Down wrap.
    step(1, 1, 3, 0, 8'h01, "ld01");
    for (int i = 0; i < 3; i++) step(1, 1, 2, $urandom, $urandom, "dn");

    // Enable gating.
    step(1, 1, 3, 0, 8'h10, "ld10");
    step(1, 1, 1, 0, 0, "up10");
    for (int i = 0; i < 4; i++) step(1, 0, 1, $urandom, $urandom, "hold");
    step(1, 1, 1, 0, 0, "res0");
    step(1, 1, 1, 0, 0, "res1");

    // Load of equal value gives no change.
    step(1, 1, 3, 0, mq, "ldeq");

    // Reset beats load; reset mid-count restarts from RST_VAL.
    step(0, 1, 3, 0, 8'hAA, "rstld");
    step(1, 1, 3, 0, 8'h32, "ld32");
    step(1, 1, 1, 0, 0, "up33");
    step(0, 1, 1, 0, 0, "rstmid");
    step(1, 1, 1, 0, 0, "restart");

    // Randomized traffic, biased towards the count limits.
    for (int i = 0; i < 400; i++) begin
      int sel;
      int lv;
      sel = int'($urandom_range(0, 3));
      lv  = (sel == 0) ? 0 : (sel == 1) ? MaxV : int'($urandom_range(0, MaxV));
      step($urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, MaxV)), lv, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tff_bank_ctr.md
Name: tff_bank_ctr

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of synchronous T flip-flops with a shared enable.
- A mode input reuses the bank as a per-bit toggle register, an up counter, a down counter, or a parallel-load register.
- Provides complementary outputs, a terminal-count flag and a change flag.
- Building block for the team's dividers and sequence generators.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (1..32).
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low. Sampled on rising clk; 0 = reset.
- en  input  1  global enable. 0 = hold all state.
- mode  input  2  00 toggle, 01 count up, 10 count down, 11 load.
- t  input  WIDTH  per-bit toggle requests; used in mode 00 only.
- load_val  input  WIDTH  parallel load data; used in mode 11 only.
- q  output  WIDTH  registered bank state.
- qb  output  WIDTH  always ~q, derived combinationally from the q register.
- tc  output  1  registered terminal-count flag.
- chg  output  1  registered flag: q changed on the last update.

Behaviour:
- Reset: on a rising clk with rst=0, regardless of en or mode:
  - q <= RST_VAL, qb = ~RST_VAL, tc <= 0, chg <= 0.
  - Reset has priority over every other event.
- Hold: en=0 and rst=1 → q holds its value; tc <= 0; chg <= 0.
- Update latency: all updates below apply with en=1, rst=1, and are visible one clock after the sampling edge.
- Mode 00 (toggle): q <= q ^ t. Bits with t[i]=0 hold; bits with t[i]=1 invert. tc <= 0.
- Mode 01 (up): q <= q + 1, modulo 2^WIDTH.
  - On wrap from all-ones to 0: tc <= 1 for that update only.
  - Otherwise tc <= 0.
- Mode 10 (down): q <= q - 1, modulo 2^WIDTH.
  - On wrap from 0 to all-ones: tc <= 1 for that update only.
  - Otherwise tc <= 0.
- Mode 11 (load): q <= load_val; tc <= 0.
- chg <= 1 exactly when the next q differs from the current q; otherwise 0.
  - Examples: toggle with t=0 gives chg=0; load of an equal value gives chg=0.
- Mode change takes effect on the next enabled edge. There is no internal state other than q, tc and chg.
- Reset mid-count: the sequence restarts from RST_VAL on the next enabled edge, with no residual tc.
- WIDTH=1 corner case: mode 00 is the classic T-FF; modes 01 and 10 both toggle q each cycle, with tc=1 on every wrap.
- Bit t is ignored outside mode 00; load_val is ignored outside mode 11.
- Blocking/non-blocking variants and latch outputs are not provided; the single registered q is the only state output.

Optional Feature:
- Macro: TFF_BANK_SAT_EN.
- Defined:
  - Modes 01 and 10 saturate instead of wrapping: up holds at all-ones, down holds at 0.
  - tc <= 1 on every enabled count cycle in which q is at the limit after the update, including the cycle it first reaches the limit.
  - chg follows the normal rule, so chg=0 while held at the limit.
- Undefined: wrap behaviour exactly as above; no saturation logic present.

Test Plan:
- Reset (WIDTH=8, RST_VAL=8'h5A): drive rst=0 for 2 clocks with en=1, mode=01 → q=8'h5A, qb=8'hA5, tc=0, chg=0. Release rst → next edge gives q=8'h5B, chg=1.
- Toggle: q=8'h0F, mode=00, t=8'hFF → q=8'hF0. Then t=8'h00 → q=8'hF0, chg=0. Then t=8'h81 → q=8'h71.
- Up wrap: load 8'hFE, then mode=01 for 3 cycles → q sequence FF, 00, 01. tc=1 only on the update producing 00. With TFF_BANK_SAT_EN → q sequence FF, FF, FF; tc=1 on all three; chg 1, 0, 0.
- Down wrap: load 8'h01, then mode=10 for 3 cycles → q sequence 00, FF, FE; tc=1 only on the update producing FF.
- Enable gating: counting up from 8'h10, drop en for 4 cycles → q stays 8'h10 (or the value at the drop), tc=0, chg=0. Raise en → counting resumes +1 per cycle.
- Simultaneous events: rst=0 together with mode=11, load_val=8'hAA, en=1 → q=RST_VAL, not 8'hAA. Asserting reset mid-count at q=8'h33 → q=RST_VAL, and the count restarts from there.
